lcd_fb_writer: RTL and testbench

Upstream of the RGB565 LCD controller: accepts a valid/ready pixel stream (RGB888 or 8-bit grayscale, e.g. CNN result or camera image) and converts it to RGB565. Writes each frame linearly into a double-buffered frame RAM that the LCD controller reads. Swaps write and display banks only during LCD vertical blanking, so the display never shows a partially written frame.

---
 rtl/lcd_fb_writer.sv | 167 ++++++++++++++++
 tb/tb_lcd_fb_writer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_writer.sv
// lcd_fb_writer: converts an RGB888/grayscale valid-ready pixel stream to
// RGB565 and writes whole frames linearly into one bank of a double-buffered
// frame RAM. Banks swap only on an LCD vsync fall after a frame is complete,
// so the display never shows a partially written frame.
module lcd_fb_writer #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iFmt,
  input  logic              iPixValid,
  input  logic              iPixSof,
  input  logic [23:0]       iPixData,
  output logic              oPixReady,
  input  logic              iLcdVSync,
  output logic              oRamWrEn,
  output logic [ADDR_W-1:0] oRamWrAddr,
  output logic [15:0]       oRamWrData,
  output logic              oWrBank,
  output logic              oRdBank,
  output logic              oFrameDone,
  output logic              oErrSof
);

  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                vs_q;

  logic                accept_c;
  logic                swap_c;
  logic [ADDR_W-1:0]   wa_c;
  logic [15:0]         rgb565_c;
  logic                unused_pix_c;

  // Pixel bits discarded by the RGB565 truncation in either format.
  assign unused_pix_c = ^{iPixData[18:16], iPixData[9:8], iPixData[1:0]};

  // Beat handshake, swap detection and target address of the current beat.
  assign accept_c = iPixValid & ready_q;
  assign swap_c   = vs_q & ~iLcdVSync;
  assign wa_c     = iPixSof ? '0 : cnt_q;

  // RGB565 conversion; grayscale replicates the luma MSBs into all channels.
  always_comb begin
    rgb565_c = {iPixData[23:19], iPixData[15:10], iPixData[7:3]};
    if (iFmt) begin
      rgb565_c = {iPixData[7:3], iPixData[7:2], iPixData[7:3]};
    end
  end

  // Next-state and registered-output logic for the frame writer FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Non-SOF beats are consumed and dropped until a frame starts.
        if (accept_c && iPixSof) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wa_c;
          wr_data_d = rgb565_c;
          if (wa_c == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = wa_c + ADDR_W'(1);
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (accept_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wa_c;
          wr_data_d = rgb565_c;
          err_d     = iPixSof;
          if (wa_c == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = wa_c + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        // Frame complete; hand it to the display on the next vsync fall.
        if (swap_c) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d != S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      done_q    <= done_d;
      err_q     <= err_d;
      vs_q      <= iLcdVSync;
    end
  end

  assign oPixReady  = ready_q;
  assign oRamWrEn   = wr_en_q;
  assign oRamWrAddr = wr_addr_q;
  assign oRamWrData = wr_data_q;
  assign oWrBank    = wr_bank_q;
  assign oRdBank    = rd_bank_q;
  assign oFrameDone = done_q;
  assign oErrSof    = err_q;

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Directed bench for lcd_fb_writer with a 4x2 frame.
module tb_lcd_fb_writer;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned AW = 3;

  logic          iClk = 1'b0;
  logic          iRsn;
  logic          iFmt;
  logic          iPixValid;
  logic          iPixSof;
  logic [23:0]   iPixData;
  logic          oPixReady;
  logic          iLcdVSync;
  logic          oRamWrEn;
  logic [AW-1:0] oRamWrAddr;
  logic [15:0]   oRamWrData;
  logic          oWrBank;
  logic          oRdBank;
  logic          oFrameDone;
  logic          oErrSof;

  int n_assert = 0;
  int n_fail   = 0;

  lcd_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .iClk(iClk), .iRsn(iRsn), .iFmt(iFmt), .iPixValid(iPixValid),
    .iPixSof(iPixSof), .iPixData(iPixData), .oPixReady(oPixReady),
    .iLcdVSync(iLcdVSync), .oRamWrEn(oRamWrEn), .oRamWrAddr(oRamWrAddr),
    .oRamWrData(oRamWrData), .oWrBank(oWrBank), .oRdBank(oRdBank),
    .oFrameDone(oFrameDone), .oErrSof(oErrSof)
  );

  always #5 iClk = ~iClk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic [23:0] d);
    iPixValid = v;
    iPixSof   = s;
    iFmt      = f;
    iPixData  = d;
  endtask

  task automatic chk1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks control/bank outputs; address and data only when a write is expected.
  task automatic chk_out(input string tag, input logic en, input logic [AW-1:0] addr,
                         input logic [15:0] data, input logic done, input logic err,
                         input logic rdy, input logic wrb, input logic rdb);
    chk1({tag, ".en"},    16'(oRamWrEn),   16'(en));
    if (en) begin
      chk1({tag, ".addr"}, 16'(oRamWrAddr), 16'(addr));
      chk1({tag, ".data"}, oRamWrData,      data);
    end
    chk1({tag, ".done"},  16'(oFrameDone), 16'(done));
    chk1({tag, ".err"},   16'(oErrSof),    16'(err));
    chk1({tag, ".ready"}, 16'(oPixReady),  16'(rdy));
    chk1({tag, ".wrbank"}, 16'(oWrBank),   16'(wrb));
    chk1({tag, ".rdbank"}, 16'(oRdBank),   16'(rdb));
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, ".addr"}, 16'(oRamWrAddr), 16'd0);
    chk1({tag, ".data"}, oRamWrData, 16'd0);
    chk_out(tag, 1'b0, '0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int acc;
    iRsn = 1'b0;
    iLcdVSync = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick();
    tick();
    chk_reset("reset");

    iRsn = 1'b1;
    tick();
    chk1("ready_after_release", 16'(oPixReady), 16'd1);

    // Frame 1: RGB888 FF8040 -> FC08 at addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, 1'b0, 24'hFF8040);
      tick();
      chk_out($sformatf("f1_beat%0d", i), 1'b1, AW'(i), 16'hFC08, i == 7, 1'b0,
              i != 7, 1'b0, 1'b1);
    end
    // Extra valid beat while DONE must not be taken.
    tick();
    chk_out("f1_no_extra", 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 24'h0);

    // Vsync fall swaps banks and reopens the input.
    iLcdVSync = 1'b0;
    tick();
    chk_out("swap1", 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    iLcdVSync = 1'b1;
    tick();

    // Non-SOF beats in IDLE are dropped.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 24'h0000A5);
      tick();
      chk_out($sformatf("idle_drop%0d", i), 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    // Frame 2: grayscale A5 -> A534.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, 1'b1, 24'hFFFFA5);
      tick();
      chk_out($sformatf("f2_beat%0d", i), 1'b1, AW'(i), 16'hA534, i == 7, 1'b0,
              i != 7, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    iLcdVSync = 1'b0;
    tick();
    chk_out("swap2", 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    iLcdVSync = 1'b1;
    tick();

    // Vsync fall while IDLE is ignored.
    iLcdVSync = 1'b0;
    tick();
    chk_out("idle_vs_fall", 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    iLcdVSync = 1'b1;
    tick();

    // Frame 3: RGB 123456 -> 11AA, early SOF at beat 5, vsync fall in WRITE,
    // last beat coinciding with a vsync fall.
    for (int i = 0; i < 13; i++) begin
      logic [AW-1:0] ea;
      ea = (i < 5) ? AW'(i) : AW'(i - 5);
      iLcdVSync = !(i == 2 || i == 12);
      drive(1'b1, i == 0 || i == 5, 1'b0, 24'h123456);
      tick();
      chk_out($sformatf("f3_beat%0d", i), 1'b1, ea, 16'h11AA, i == 12, i == 5,
              i != 12, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick();
    chk_out("f3_no_swap_coincident", 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    iLcdVSync = 1'b1;
    tick();
    chk_out("f3_wait_high", 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    iLcdVSync = 1'b0;
    tick();
    chk_out("swap3", 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    iLcdVSync = 1'b1;
    tick();

    // Frame 4: random valid gaps, then reset mid-frame.
    acc = 0;
    for (int c = 0; c < 60 && acc < 5; c++) begin
      logic v;
      v = (acc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(v, acc == 0, 1'b0, 24'hFF8040);
      tick();
      chk_out($sformatf("f4_cyc%0d", c), v, AW'(acc), 16'hFC08, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (v) acc++;
    end
    chk1("f4_accepted_beats", 16'(acc), 16'd5);
    iRsn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040);
    tick();
    chk_reset("mid_reset");
    iRsn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick();
    chk1("ready_after_rerelease", 16'(oPixReady), 16'd1);
    // Partial frame abandoned: a non-SOF beat is not written.
    drive(1'b1, 1'b0, 1'b0, 24'hFF8040);
    tick();
    chk_out("post_reset_no_sof", 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
